plic_gateway: RTL and testbench

Per-source interrupt gateway for the custom RV PLIC. It converts raw level- or edge-triggered interrupt lines into a registered pending vector `ip_o`. That vector is the input of the priority/zero-count search stage directly downstream. The gateway also implements the claim/complete handshake, so each source has at most one request in flight.

---
 rtl/plic_gateway.sv | 180 ++++++++++++++++++
 tb/tb_plic_gateway.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plic_gateway.sv
// plic_gateway
// Per-source interrupt gateway for the RV PLIC. Converts raw level- or
// edge-triggered interrupt lines into the registered pending vector that
// feeds the priority search stage, and runs the claim/complete handshake
// so each source has at most one request in flight.
//
// Ports:
//   clk_i            clock, all state updates on the rising edge
//   rst_i            synchronous active-high reset
//   irq_src_i        raw interrupt lines, bit k-1 belongs to source ID k
//   le_i             trigger mode per source, 1 = rising edge, 0 = level high
//   claim_valid_i    claim of claim_id_i this cycle
//   claim_id_i       source ID being claimed (0 = none)
//   complete_valid_i completion of complete_id_i this cycle
//   complete_id_i    source ID being completed (0 = none)
//   ip_o             registered pending vector
//   in_service_o     registered claimed-not-completed vector
//
// Build option:
//   PLIC_GATEWAY_SYNC_EN  when defined, irq_src_i passes through a 2-flop
//                         synchronizer first (line to ip_o latency 3 cycles);
//                         when undefined, lines must be synchronous to clk_i
//                         (latency 1 cycle).
module plic_gateway #(
  parameter int NUM_SRC      = 32,
  parameter int MAX_EDGE_CNT = 7,
  parameter int ID_WIDTH     = $clog2(NUM_SRC + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_SRC-1:0]  irq_src_i,
  input  logic [NUM_SRC-1:0]  le_i,
  input  logic                claim_valid_i,
  input  logic [ID_WIDTH-1:0] claim_id_i,
  input  logic                complete_valid_i,
  input  logic [ID_WIDTH-1:0] complete_id_i,
  output logic [NUM_SRC-1:0]  ip_o,
  output logic [NUM_SRC-1:0]  in_service_o
);

  localparam int CNT_W = $clog2(MAX_EDGE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_EDGE_CNT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_CLAIMED = 2'd2
  } state_e;

  state_e           state_q [NUM_SRC];
  logic [CNT_W-1:0] cnt_q   [NUM_SRC];
  logic [CNT_W-1:0] cnt_nxt [NUM_SRC];
  logic [NUM_SRC-1:0] hist_q;
  logic [NUM_SRC-1:0] ip_q;
  logic [NUM_SRC-1:0] in_service_q;

  logic [NUM_SRC-1:0] line;
  logic [NUM_SRC-1:0] edge_det;
  logic [NUM_SRC-1:0] claim_hit;
  logic [NUM_SRC-1:0] complete_hit;
  logic [NUM_SRC-1:0] claim_take;
  logic [NUM_SRC-1:0] req_nxt;

  // Edge counter update. An edge coinciding with a claim cancels out, which
  // also keeps a saturated counter at its ceiling in that case. The counter
  // is only meaningful in edge mode; level mode holds it at zero.
  function automatic logic [CNT_W-1:0] cnt_update(
    input logic             edge_mode,
    input logic             edge_seen,
    input logic             take,
    input logic [CNT_W-1:0] cnt
  );
    logic [CNT_W-1:0] res;
    res = cnt;
    if (!edge_mode) begin
      res = '0;
    end else if (take && edge_seen) begin
      res = cnt;
    end else if (take) begin
      res = (cnt != '0) ? cnt - 1'b1 : '0;
    end else if (edge_seen && (cnt != CNT_MAX)) begin
      res = cnt + 1'b1;
    end
    return res;
  endfunction

`ifdef PLIC_GATEWAY_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q;
  logic [NUM_SRC-1:0] sync2_q;

  // Synchronizer stages
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src_i;
      sync2_q <= sync1_q;
    end
  end

  assign line = sync2_q;
`else
  assign line = irq_src_i;
`endif

  // IDs that do not name a source (0 or > NUM_SRC) never match any index,
  // so the decoder drops them without extra logic.
  always_comb begin
    edge_det     = '0;
    claim_hit    = '0;
    complete_hit = '0;
    claim_take   = '0;
    req_nxt      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      edge_det[i]     = le_i[i] & line[i] & ~hist_q[i];
      claim_hit[i]    = claim_valid_i && (claim_id_i == ID_WIDTH'(i + 1));
      complete_hit[i] = complete_valid_i && (complete_id_i == ID_WIDTH'(i + 1));
      claim_take[i]   = claim_hit[i] && (state_q[i] == S_PENDING);
      cnt_nxt[i]      = cnt_update(le_i[i], edge_det[i], claim_take[i], cnt_q[i]);
      // Whether a new request is waiting once this cycle's events are applied
      req_nxt[i]      = le_i[i] ? (cnt_nxt[i] != '0) : line[i];
    end
  end

  // Gateway state, counters and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
      hist_q       <= '0;
      ip_q         <= '0;
      in_service_q <= '0;
    end else begin
      hist_q <= line;
      for (int i = 0; i < NUM_SRC; i++) begin
        cnt_q[i] <= cnt_nxt[i];
        case (state_q[i])
          S_IDLE: begin
            if (req_nxt[i]) begin
              state_q[i] <= S_PENDING;
              ip_q[i]    <= 1'b1;
            end
          end
          S_PENDING: begin
            if (claim_hit[i]) begin
              state_q[i]      <= S_CLAIMED;
              ip_q[i]         <= 1'b0;
              in_service_q[i] <= 1'b1;
            end
          end
          S_CLAIMED: begin
            // Line activity is ignored here except for edge counting;
            // completion re-evaluates whether another request is waiting.
            if (complete_hit[i]) begin
              in_service_q[i] <= 1'b0;
              if (req_nxt[i]) begin
                state_q[i] <= S_PENDING;
                ip_q[i]    <= 1'b1;
              end else begin
                state_q[i] <= S_IDLE;
              end
            end
          end
          default: begin
            state_q[i]      <= S_IDLE;
            ip_q[i]         <= 1'b0;
            in_service_q[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ip_o         = ip_q;
  assign in_service_o = in_service_q;

endmodule

// File: tb/tb_plic_gateway.sv
// Testbench for plic_gateway: directed scenarios followed by random traffic,
// checked every cycle against a reference model through a scoreboard queue.
module tb_plic_gateway;

  localparam int N   = 32;
  localparam int MAX = 7;
  localparam int IW  = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_src;
  logic [N-1:0]  le;
  logic          claim_valid;
  logic [IW-1:0] claim_id;
  logic          complete_valid;
  logic [IW-1:0] complete_id;
  logic [N-1:0]  ip;
  logic [N-1:0]  in_service;

  plic_gateway #(.NUM_SRC(N), .MAX_EDGE_CNT(MAX)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .irq_src_i        (irq_src),
    .le_i             (le),
    .claim_valid_i    (claim_valid),
    .claim_id_i       (claim_id),
    .complete_valid_i (complete_valid),
    .complete_id_i    (complete_id),
    .ip_o             (ip),
    .in_service_o     (in_service)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  logic [2*N-1:0] exp_q [$];

  // Reference model: each source either holds a waiting request, is being
  // serviced, or neither; edge mode additionally owes a number of requests.
  bit [N-1:0] m_pend, m_isv, m_hist, m_s1, m_s2;
  int         m_owed [N];

  logic [N-1:0] irq_v;
  logic [N-1:0] le_v;

  task automatic model_step(input logic r, input logic cv, input int cid,
                            input logic pv, input int pid);
    bit [N-1:0] ln;
    bit         edg, clm, cmp, want;
    int         owed;
    if (r) begin
      m_pend = '0; m_isv = '0; m_hist = '0; m_s1 = '0; m_s2 = '0;
      for (int i = 0; i < N; i++) m_owed[i] = 0;
      return;
    end
`ifdef PLIC_GATEWAY_SYNC_EN
    ln = m_s2;
`else
    ln = irq_v;
`endif
    for (int i = 0; i < N; i++) begin
      edg = le_v[i] && ln[i] && !m_hist[i];
      clm = cv && (cid == i + 1) && m_pend[i];
      cmp = pv && (pid == i + 1) && m_isv[i];
      if (le_v[i]) begin
        owed = m_owed[i] + (edg ? 1 : 0) - (clm ? 1 : 0);
        if (owed > MAX) owed = MAX;
        if (owed < 0) owed = 0;
      end else begin
        owed = 0;
      end
      m_owed[i] = owed;
      want = le_v[i] ? (owed > 0) : ln[i];
      if (clm) begin
        m_pend[i] = 1'b0;
        m_isv[i]  = 1'b1;
      end else if (cmp) begin
        m_isv[i]  = 1'b0;
        m_pend[i] = want;
      end else if (!m_pend[i] && !m_isv[i]) begin
        m_pend[i] = want;
      end
    end
    m_hist = ln;
    m_s2   = m_s1;
    m_s1   = irq_v;
  endtask

  // One clock of stimulus: drive on the falling edge, predict, enqueue.
  task automatic step(input logic cv, input int cid, input logic pv,
                      input int pid, input logic r);
    @(negedge clk);
    rst            = r;
    irq_src        = irq_v;
    le             = le_v;
    claim_valid    = cv;
    claim_id       = IW'(cid);
    complete_valid = pv;
    complete_id    = IW'(pid);
    model_step(r, cv, cid, pv, pid);
    exp_q.push_back({m_pend, m_isv});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic do_claim(input int id);
    step(1'b1, id, 1'b0, 0, 1'b0);
  endtask

  task automatic do_complete(input int id);
    step(1'b0, 0, 1'b1, id, 1'b0);
  endtask

  task automatic pulse(input int b);
    irq_v[b] = 1'b1;
    idle(1);
    irq_v[b] = 1'b0;
    idle(1);
  endtask

  // Monitor: one expected pair per clock, compared after the edge settles
  initial begin
    logic [2*N-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (ip !== e[2*N-1:N]) begin
          bad++;
          $display("FAIL ip_o cyc=%0d got=%h exp=%h", cycle, ip, e[2*N-1:N]);
        end
        total++;
        if (in_service !== e[N-1:0]) begin
          bad++;
          $display("FAIL in_service_o cyc=%0d got=%h exp=%h", cycle, in_service, e[N-1:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    int cid, pid;
    logic cv, pv, r;
    irq_v = '0;
    le_v  = '0;
    rst = 1'b1; irq_src = '0; le = '0;
    claim_valid = 1'b0; claim_id = '0; complete_valid = 1'b0; complete_id = '0;

    // Reset state
    step(1'b0, 0, 1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0, 0, 1'b1);
    idle(8);

    // Level basic: source 5 (bit 4)
    irq_v[4] = 1'b1;
    idle(2);
    do_claim(5);
    idle(2);
    do_complete(5);
    idle(1);
    irq_v[4] = 1'b0;
    do_claim(5);
    idle(1);
    do_complete(5);
    idle(2);

    // Edge counting on source 1
    le_v = 32'h1;
    idle(1);
    for (int k = 0; k < 3; k++) pulse(0);
    for (int k = 0; k < 3; k++) begin
      do_claim(1);
      idle(1);
      do_complete(1);
      idle(1);
    end
    idle(2);

    // Saturation on source 3
    le_v = 32'h4;
    idle(1);
    for (int k = 0; k < 10; k++) pulse(2);
    for (int k = 0; k < MAX + 1; k++) begin
      do_claim(3);
      do_complete(3);
    end
    idle(2);

    // Illegal handshakes; source 3 pending in level mode
    le_v = '0;
    irq_v[2] = 1'b1;
    idle(2);
    do_claim(0);
    do_claim(33);
    do_claim(7);
    do_complete(3);
    do_complete(0);
    idle(1);
    do_claim(3);
    irq_v[2] = 1'b0;
    idle(1);
    do_complete(3);
    idle(2);

    // Simultaneous edge and claim on source 2
    le_v = 32'h2;
    idle(1);
    pulse(1);
    irq_v[1] = 1'b1;
    do_claim(2);
    irq_v[1] = 1'b0;
    idle(1);
    do_complete(2);
    idle(1);
    do_claim(2);
    do_complete(2);
    idle(2);
    // Claim and complete of different IDs in one cycle
    le_v = 32'h2;
    pulse(1);
    irq_v[9] = 1'b1;
    idle(1);
    do_claim(2);
    step(1'b1, 10, 1'b1, 2, 1'b0);
    irq_v[9] = 1'b0;
    do_complete(10);
    idle(2);

    // Reset mid-operation with mixed states and non-zero counters
    le_v = 32'h3;
    pulse(0); pulse(0); pulse(1); pulse(1);
    irq_v[7] = 1'b1;
    idle(1);
    do_claim(1);
    idle(1);
    step(1'b0, 0, 1'b0, 0, 1'b1);
    irq_v = '0;
    idle(4);

    // Mode change keeps pending request
    le_v = 32'h10;
    pulse(4);
    le_v = '0;
    idle(2);
    do_claim(5);
    do_complete(5);
    idle(2);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      irq_v = irq_v ^ ($urandom() & $urandom() & $urandom());
      if ($urandom_range(63) == 0) le_v = $urandom();
      cv  = ($urandom_range(3) != 0);
      cid = ($urandom_range(9) == 0) ? $urandom_range(40) : $urandom_range(1, N);
      pv  = ($urandom_range(3) != 0);
      pid = ($urandom_range(9) == 0) ? $urandom_range(40) : $urandom_range(1, N);
      if ($urandom_range(3) == 0) pid = cid;
      r   = ($urandom_range(499) == 0);
      step(cv, cid, pv, pid, r);
    end
    idle(3);

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain cyc=%0d got=%0d exp=0", cycle, exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
